// File: rtl/kalman_eng_if.sv
// Engine-side bus for kalman_bin_sequencer.
// The sequencer (master) drives the start pulse, the fed-back state and the
// per-bin ROM base addresses. The LDL iteration engine (slave) returns state
// words and an end-of-bin pulse.
//   start  : 1-cycle start pulse to the engine
//   finish : engine end-of-bin pulse
//   data_v : engine state word valid
//   data   : engine state word (word 0, then word 1)
//   state  : {s1,s0} presented to the engine's data_in
//   z_base : Z ROM base of the current bin (bin*COL)
//   k_base : K ROM base of the current bin (bin*COL*COL)
interface kalman_eng_if #(
  parameter int DATA_W = 32,
  parameter int Z_W    = 15,
  parameter int K_W    = 22
) ();
  logic                start;
  logic                finish;
  logic                data_v;
  logic [DATA_W-1:0]   data;
  logic [2*DATA_W-1:0] state;
  logic [Z_W-1:0]      z_base;
  logic [K_W-1:0]      k_base;

  modport master (
    output start, state, z_base, k_base,
    input  finish, data_v, data
  );

  modport slave (
    input  start, state, z_base, k_base,
    output finish, data_v, data
  );
endinterface

// File: rtl/kalman_bin_sequencer.sv
// Step controller for the Kalman LDL iteration engine. Walks the engine
// through NUM_BINS bins: pulses start, supplies Z/K ROM base addresses,
// captures the 2-word state the engine returns and feeds it back for the
// next bin.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   run_i       : start a full run (accepted in IDLE/DONE only)
//   abort_i     : abandon the run, return to IDLE (highest priority)
//   eng         : engine bus (master side), see kalman_eng_if
//   res_v_o     : 1-cycle, res_o holds a completed bin's {s1,s0}
//   res_o       : completed bin state {s1,s0}
//   busy_o      : high in LAUNCH/RUN/GAP
//   done_o      : 1-cycle pulse on run completion (normal or timeout)
//   err_o       : sticky [0]=watchdog timeout, [1]=word-count error
//   bin_idx_o   : current bin
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for run_i
// LAUNCH  | eng.start high for this single cycle
// RUN     | collecting state words, waiting for finish, watchdog live
// GAP     | idle spacing before the next bin's launch
// DONE    | run complete, waiting for run_i to restart
module kalman_bin_sequencer #(
  parameter int                       COL      = 96,
  parameter int                       DATA_W   = 32,
  parameter int                       NUM_BINS = 140,
  parameter logic signed [DATA_W-1:0] INIT_S0  = 200587,
  parameter logic signed [DATA_W-1:0] INIT_S1  = -676877,
  parameter int                       GAP      = 3,
  parameter int                       TMO_W    = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run_i,
  input  logic                        abort_i,
  kalman_eng_if.master                eng,
  output logic                        res_v_o,
  output logic [2*DATA_W-1:0]         res_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [1:0]                  err_o,
  output logic [$clog2(NUM_BINS):0]   bin_idx_o
);

  localparam int Z_W   = $clog2(COL*NUM_BINS) + 1;
  localparam int K_W   = $clog2(COL*COL*NUM_BINS) + 1;
  localparam int BIN_W = $clog2(NUM_BINS) + 1;
  localparam int GAP_W = $clog2(GAP) + 1;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [Z_W-1:0]   Z_STEP   = Z_W'(COL);
  localparam logic [K_W-1:0]   K_STEP   = K_W'(COL*COL);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
  // Down-counter reaching 0 on the (2**TMO_W-1)-th RUN cycle without finish.
  localparam logic [TMO_W-1:0] WD_LOAD  = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                start_q;
  logic                res_v_q;
  logic                done_q;
  logic                busy_q;
  logic [1:0]          err_q;
  logic [DATA_W-1:0]   s0_q;
  logic [DATA_W-1:0]   s1_q;
  logic [2*DATA_W-1:0] res_q;
  logic [BIN_W-1:0]    bin_q;
  logic [Z_W-1:0]      z_base_q;
  logic [K_W-1:0]      k_base_q;
  logic [1:0]          wc_q;
  logic [TMO_W-1:0]    wd_q;
  logic [GAP_W-1:0]    gap_q;

  // State words including one arriving this cycle, so a finish coincident
  // with the last word still reports the complete state.
  logic [DATA_W-1:0] s0_d;
  logic [DATA_W-1:0] s1_d;
  logic [1:0]        wc_d;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    wc_d = wc_q;
    if (state_q == S_RUN && eng.data_v) begin
      if (!wc_q[0]) s0_d = eng.data;
      else          s1_d = eng.data;
      // Saturate so an overlong burst cannot wrap back to a "good" count.
      wc_d = (wc_q == 2'd3) ? 2'd3 : wc_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      res_v_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 2'b00;
      s0_q     <= INIT_S0;
      s1_q     <= INIT_S1;
      res_q    <= '0;
      bin_q    <= '0;
      z_base_q <= '0;
      k_base_q <= '0;
      wc_q     <= 2'd0;
      wd_q     <= '0;
      gap_q    <= '0;
    end else begin
      start_q <= 1'b0;
      res_v_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (run_i) begin
              state_q  <= S_LAUNCH;
              start_q  <= 1'b1;
              busy_q   <= 1'b1;
              err_q    <= 2'b00;
              s0_q     <= INIT_S0;
              s1_q     <= INIT_S1;
              bin_q    <= '0;
              z_base_q <= '0;
              k_base_q <= '0;
              wc_q     <= 2'd0;
            end
          end
          S_LAUNCH: begin
            state_q <= S_RUN;
            wd_q    <= WD_LOAD;
          end
          S_RUN: begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            wc_q <= wc_d;
            if (eng.finish) begin
              res_v_q <= 1'b1;
              res_q   <= {s1_d, s0_d};
              if (wc_d != 2'd2) err_q[1] <= 1'b1;
              if (bin_q == LAST_BIN) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q  <= S_GAP;
                gap_q    <= GAP_LOAD;
                bin_q    <= bin_q + BIN_W'(1);
                z_base_q <= z_base_q + Z_STEP;
                k_base_q <= k_base_q + K_STEP;
                wc_q     <= 2'd0;
              end
            end else if (wd_q == '0) begin
              err_q[0] <= 1'b1;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              wd_q <= wd_q - TMO_W'(1);
            end
          end
          S_GAP: begin
            if (gap_q == '0) begin
              state_q <= S_LAUNCH;
              start_q <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign eng.start  = start_q;
  assign eng.state  = {s1_q, s0_q};
  assign eng.z_base = z_base_q;
  assign eng.k_base = k_base_q;
  assign res_v_o    = res_v_q;
  assign res_o      = res_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign bin_idx_o  = bin_q;

endmodule

// File: tb/tb_kalman_bin_sequencer.sv
module tb_kalman_bin_sequencer;
  localparam int COL   = 96;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int GAP   = 3;
  localparam int TMO_W = 6;
  localparam int Z_W   = $clog2(COL*NB) + 1;
  localparam int K_W   = $clog2(COL*COL*NB) + 1;
  localparam int BIN_W = $clog2(NB) + 1;
  localparam logic signed [31:0] INIT_S0 = 200587;
  localparam logic signed [31:0] INIT_S1 = -676877;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             res_v;
  logic [63:0]      res;
  logic             busy;
  logic             done;
  logic [1:0]       err;
  logic [BIN_W-1:0] bin_idx;

  kalman_eng_if #(.DATA_W(DW), .Z_W(Z_W), .K_W(K_W)) eng ();

  kalman_bin_sequencer #(
    .COL(COL), .DATA_W(DW), .NUM_BINS(NB), .INIT_S0(INIT_S0),
    .INIT_S1(INIT_S1), .GAP(GAP), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .abort_i(abort_i),
    .eng(eng), .res_v_o(res_v), .res_o(res), .busy_o(busy),
    .done_o(done), .err_o(err), .bin_idx_o(bin_idx)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  // Reference state: what the engine model has returned so far this run.
  logic [31:0] exp_s0;
  logic [31:0] exp_s1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic wait_start(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (eng.start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_run();
    run_i = 1'b1;
    @(negedge clk);
    run_i = 1'b0;
    exp_s0 = INIT_S0;
    exp_s1 = INIT_S1;
    chk("run_to_start", eng.start, 1);
  endtask

  task automatic bin_checks(input int k);
    chk($sformatf("bin_idx_%0d", k), bin_idx, k);
    chk($sformatf("z_base_%0d", k), eng.z_base, k*COL);
    chk($sformatf("k_base_%0d", k), eng.k_base, k*COL*COL);
    chk($sformatf("state_in_%0d", k), eng.state, {exp_s1, exp_s0});
    chk($sformatf("busy_%0d", k), busy, 1);
  endtask

  // Engine model for one bin; called while eng.start is visible.
  task automatic do_bin(input int k, input int nwords, input bit coincide,
                        input bit poke_run, input bit do_abort);
    logic [31:0] dd;
    bin_checks(k);
    @(negedge clk);
    chk("start_one_cycle", eng.start, 0);
    if (poke_run) begin
      run_i = 1'b1;
      @(negedge clk);
      run_i = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      dd = $urandom_range(1, 5000);
      if (w == 0) exp_s0 = exp_s0 + dd;
      else        exp_s1 = exp_s1 + dd;
      eng.data_v = 1'b1;
      eng.data   = (w == 0) ? exp_s0 : exp_s1;
      eng.finish = coincide && (w == nwords - 1);
      abort_i    = do_abort && eng.finish;
      @(negedge clk);
    end
    if (!coincide) begin
      eng.data_v = 1'b0;
      eng.finish = 1'b1;
      abort_i    = do_abort;
      @(negedge clk);
    end
    eng.data_v = 1'b0;
    eng.finish = 1'b0;
    abort_i    = 1'b0;
    if (do_abort) begin
      chk("abort_no_res_v", res_v, 0);
      chk("abort_no_done", done, 0);
      chk("abort_busy", busy, 0);
    end else begin
      chk($sformatf("res_v_%0d", k), res_v, 1);
      chk($sformatf("res_%0d", k), res, {exp_s1, exp_s0});
      chk($sformatf("done_at_%0d", k), done, (k == NB-1) ? 1 : 0);
      chk($sformatf("busy_after_%0d", k), busy, (k == NB-1) ? 0 : 1);
    end
  endtask

  task automatic next_start();
    int n;
    wait_start(n);
    chk("finish_to_start", n + 1, GAP + 1);
  endtask

  task automatic run_full(input int short_bin, input int poke_bin);
    start_run();
    for (int k = 0; k < NB; k++) begin
      if (k > 0) next_start();
      do_bin(k, (k == short_bin) ? 1 : 2, 1'($urandom_range(0, 1)), k == poke_bin, 1'b0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int n;
    logic act;
    eng.finish = 1'b0;
    eng.data_v = 1'b0;
    eng.data   = '0;

    repeat (3) @(negedge clk);
    chk("rst_state", eng.state, {INIT_S1, INIT_S0});
    chk("rst_start", eng.start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", {res_v, res}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full run with state feedback; a run_i while busy is ignored.
    run_full(-1, 1);
    chk("err_clean", err, 0);
    act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      act = act | eng.start | res_v | done | busy;
    end
    chk("done_quiet", act, 0);

    // Short bin 0: word-count error, run still completes.
    run_full(0, -1);
    chk("err_wordcnt", err, 2'b10);

    // Watchdog: engine never finishes.
    start_run();
    chk("err_cleared", err, 0);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_err", err, 2'b01);
    chk("timeout_busy", busy, 0);
    chk("timeout_state", eng.state, {INIT_S1, INIT_S0});
    @(negedge clk);
    chk("timeout_done_pulse", done, 0);

    // Abort in bin 2 with a coincident finish.
    start_run();
    do_bin(0, 2, 1'b0, 1'b0, 1'b0);
    next_start();
    do_bin(1, 2, 1'b1, 1'b0, 1'b0);
    next_start();
    do_bin(2, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    act = 1'b0;
    repeat (10) begin
      @(negedge clk);
      act = act | eng.start | res_v | done | busy;
    end
    chk("abort_quiet", act, 0);

    // Async reset in the middle of bin 1.
    start_run();
    do_bin(0, 2, 1'b1, 1'b0, 1'b0);
    next_start();
    bin_checks(1);
    @(negedge clk);
    exp_s0 = exp_s0 + 32'd7;
    eng.data_v = 1'b1;
    eng.data   = exp_s0;
    @(negedge clk);
    eng.data_v = 1'b0;
    chk("pre_rst_state", eng.state, {exp_s1, exp_s0});
    rst_n = 1'b0;
    #1;
    chk("arst_state", eng.state, {INIT_S1, INIT_S0});
    chk("arst_busy", busy, 0);
    chk("arst_bin", bin_idx, 0);
    chk("arst_bases", {eng.z_base, eng.k_base}, 0);
    chk("arst_pulses", {eng.start, res_v, done}, 0);
    chk("arst_res", res, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
